// File: rtl/bpsk_demod.sv
// BPSK correlating demodulator: multiplies each symbol's samples by a local reference sine
// and decides the bit from the sign of the summed products.
module bpsk_demod #(
  parameter int WIDTH  = 8,
  parameter int SIZE   = 64,
  parameter int THRESH = 4096,
  parameter int ACC_W  = 2*WIDTH + $clog2(SIZE) + 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] sample_i,
  input  logic             sample_valid_i,
  output logic             bit_out_o,
  output logic             bit_valid_o,
  output logic [ACC_W-1:0] corr_out_o,
  output logic             low_conf_o,
  output logic             busy_o
);
  localparam int IDX_W  = $clog2(SIZE);
  localparam int PROD_W = 2*WIDTH + 2;
  localparam logic [WIDTH-1:0] MID = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {IDLE, INTEG} state_t;

  // Reference table is elaborated from the same rounding rule the modulator table uses.
  function automatic logic [WIDTH-1:0] sine_at(input int k);
    real mid, amp, ph;
    mid = real'(2**(WIDTH-1));
    amp = mid - 1.0;
    ph  = 6.283185307179586 * real'(k) / real'(SIZE);
    return WIDTH'($rtoi(mid + amp * $sin(ph) + 0.5));
  endfunction

  logic [WIDTH-1:0] rom [SIZE];
  for (genvar g = 0; g < SIZE; g++) begin : g_rom
    assign rom[g] = sine_at(g);
  end

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic                     bit_q, bit_d;
  logic                     bv_q, bv_d;
  logic [ACC_W-1:0]         corr_q, corr_d;
  logic                     lc_q, lc_d;

  logic signed [WIDTH:0]    s, r;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  sum;
  logic [ACC_W-1:0]         mag;
  logic                     accept;

  assign accept = en_i & sample_valid_i;
  assign s      = $signed({1'b0, sample_i})   - $signed({1'b0, MID});
  assign r      = $signed({1'b0, rom[idx_q]}) - $signed({1'b0, MID});
  assign prod   = PROD_W'(s) * PROD_W'(r);
  // acc is held at zero in IDLE, so the first product of a symbol lands cleanly.
  assign sum    = acc_q + ACC_W'(prod);
  assign mag    = sum[ACC_W-1] ? ACC_W'(-sum) : ACC_W'(sum);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    bit_d   = bit_q;
    bv_d    = 1'b0;
    corr_d  = corr_q;
    lc_d    = lc_q;
    if (!en_i) begin
      state_d = IDLE;
      acc_d   = '0;
      idx_d   = '0;
    end else if (accept) begin
      if (state_q == INTEG && idx_q == IDX_W'(SIZE-1)) begin
        corr_d  = sum;
        bit_d   = ~sum[ACC_W-1];
        lc_d    = (mag < ACC_W'(THRESH));
        bv_d    = 1'b1;
        acc_d   = '0;
        idx_d   = '0;
        state_d = IDLE;
      end else begin
        acc_d   = sum;
        idx_d   = idx_q + 1'b1;
        state_d = INTEG;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      acc_q   <= '0;
      idx_q   <= '0;
      bit_q   <= 1'b0;
      bv_q    <= 1'b0;
      corr_q  <= '0;
      lc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      bit_q   <= bit_d;
      bv_q    <= bv_d;
      corr_q  <= corr_d;
      lc_q    <= lc_d;
    end
  end

  assign bit_out_o   = bit_q;
  assign bit_valid_o = bv_q;
  assign corr_out_o  = corr_q;
  assign low_conf_o  = lc_q;
  assign busy_o      = (state_q == INTEG);
endmodule
